// File: rtl/pulse_input_conditioner_pkg.sv
// Shared types and constants for the pulse-mode input conditioner.
package pulse_input_conditioner_pkg;

  localparam int unsigned DEF_DB_CYCLES  = 1_000_000;
  localparam int unsigned DEF_GAP_CYCLES = 16;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_X1  = 0;
  localparam int unsigned CH_X2  = 1;
  localparam int unsigned CH_X3  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    LOCK = 2'd2
  } state_t;

  // True when exactly one bit of a channel vector is set.
  function automatic logic one_hot3(input logic [NUM_CH-1:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/pulse_input_conditioner_if.sv
// Raw switch inputs and conditioned pulse outputs of the input stage.
interface pulse_input_conditioner_if;
  logic s3;
  logic s2;
  logic s0;
  logic x1;
  logic x2;
  logic x3;
  logic busy;
  logic err;

  modport master (output s3, s2, s0, input x1, x2, x3, busy, err);
  modport slave  (input s3, s2, s0, output x1, x2, x3, busy, err);
endinterface

// File: rtl/pulse_input_conditioner_debounce_channel.sv
// One input channel: 2-flop synchronizer, counting debouncer and
// a registered rising-edge request pulse aligned with the level flip.
module debounce_channel #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rd,
  input  logic raw,
  output logic lvl,
  output logic req
);
  localparam int unsigned CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rd) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      req   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      req   <= 1'b0;
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // Counter would reach DB_CYCLES on this edge: accept the new level.
        lvl <= ~lvl;
        req <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_input_conditioner.sv
// Conditions S3/S2/S0 into mutually exclusive one-cycle pulses x1/x2/x3,
// spacing pulses by a lockout gap and flagging dropped requests on err.
module pulse_input_conditioner
  import pulse_input_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = DEF_DB_CYCLES,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input logic                       clk,
  input logic                       rd,
  pulse_input_conditioner_if.slave  bus
);
  localparam int unsigned GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] req;

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_x1 (
    .clk(clk), .rd(rd), .raw(bus.s3), .lvl(lvl[CH_X1]), .req(req[CH_X1])
  );
  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_x2 (
    .clk(clk), .rd(rd), .raw(bus.s2), .lvl(lvl[CH_X2]), .req(req[CH_X2])
  );
  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_db_x3 (
    .clk(clk), .rd(rd), .raw(bus.s0), .lvl(lvl[CH_X3]), .req(req[CH_X3])
  );

  state_t            state;
  state_t            state_nx;
  logic [GW-1:0]     gap;
  logic [GW-1:0]     gap_nx;
  logic [NUM_CH-1:0] x_nx;
  logic              err_nx;
  logic [NUM_CH-1:0] x_q;
  logic              busy_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (!rd) begin
      state  <= IDLE;
      gap    <= '0;
      x_q    <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      gap    <= gap_nx;
      x_q    <= x_nx;
      busy_q <= (state_nx != IDLE);
      err_q  <= err_nx;
    end
  end

  // Arbiter: a lone request with every other channel released fires;
  // anything else that carries a request is dropped with err.
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    x_nx     = '0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          if (one_hot3(req) && ((lvl & ~req) == '0)) begin
            x_nx     = req;
            state_nx = FIRE;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      FIRE: begin
        err_nx   = |req;
        gap_nx   = '0;
        state_nx = LOCK;
      end
      LOCK: begin
        err_nx = |req;
        if ((gap >= GW'(GAP_CYCLES)) && (lvl == '0)) begin
          state_nx = IDLE;
        end else if (gap < GW'(GAP_CYCLES)) begin
          gap_nx = gap + GW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.x1   = x_q[CH_X1];
  assign bus.x2   = x_q[CH_X2];
  assign bus.x3   = x_q[CH_X3];
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_pulse_input_conditioner.sv
// Self-checking bench: scenario tasks plus random stimulus against a
// sample-window reference model of the conditioner.
module tb_pulse_input_conditioner;
  localparam int unsigned DB  = 4;
  localparam int unsigned GAP = 3;

  logic clk = 1'b0;
  logic rd  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pulse_input_conditioner_if ifc();

  pulse_input_conditioner #(.DB_CYCLES(DB), .GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rd (rd),
    .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model. Channel bit 0/1/2 = s3/s2/s0 = x1/x2/x3.
  // A level is accepted once the last DB synchronized samples all disagree
  // with the current debounced level; mode 0/1/2 = idle/firing/locked.
  bit [2:0]    m_sa, m_sb, m_lvl, m_req, m_x;
  bit [DB-1:0] m_win [3];
  bit          m_busy, m_err;
  int          m_mode, m_lock;

  always @(posedge clk) begin : model
    bit [2:0] raw;
    bit [2:0] nreq;
    int       n;
    raw = {ifc.s0, ifc.s2, ifc.s3};
    if (!rd) begin
      m_sa = 0; m_sb = 0; m_lvl = 0; m_req = 0; m_x = 0;
      m_busy = 0; m_err = 0; m_mode = 0; m_lock = 0;
      for (int c = 0; c < 3; c++) m_win[c] = '0;
    end else begin
      m_err = 0;
      m_x   = 0;
      n     = $countones(m_req);
      case (m_mode)
        0: begin
          if (n == 1 && (m_lvl & ~m_req) == 3'b000) begin
            m_x = m_req; m_mode = 1;
          end else if (n > 0) begin
            m_err = 1;
          end
        end
        1: begin
          m_err = (n > 0); m_mode = 2; m_lock = 0;
        end
        default: begin
          m_err = (n > 0);
          if (m_lock >= GAP && m_lvl == 3'b000) m_mode = 0;
          else m_lock++;
        end
      endcase
      m_busy = (m_mode != 0);
      nreq = 0;
      for (int c = 0; c < 3; c++) begin
        m_win[c] = {m_win[c][DB-2:0], m_sb[c]};
        if (m_win[c] == {DB{~m_lvl[c]}}) begin
          m_lvl[c] = ~m_lvl[c];
          nreq[c]  = m_lvl[c];
        end
      end
      m_req = nreq;
      m_sb  = m_sa;
      m_sa  = raw;
    end
  end

  logic [4:0] act_v, exp_v;
  assign act_v = {ifc.x3, ifc.x2, ifc.x1, ifc.busy, ifc.err};
  assign exp_v = {m_x, m_busy, m_err};

  // Apply inputs {s0,s2,s3}, advance one clock, land on the falling edge.
  task automatic cyc(input bit [2:0] s);
    ifc.s3 = s[0];
    ifc.s2 = s[1];
    ifc.s0 = s[2];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rd = 1'b1;
      cyc(i[0] ? 3'b000 : 3'b001);
      checks++;
      if (act_v !== 5'b0) begin
        errors++;
        $display("FAIL reset_zero cycle %0d: got %b want 00000", i, act_v);
      end
    end
    for (int i = 0; i < 12; i++) begin
      cyc(3'b000);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_settle cycle %0d: got %b want %b", i, act_v, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int cnt   = 0;
    int other = 0;
    for (int i = 0; i < 40; i++) begin
      cyc((i < 12) ? 3'b001 : 3'b000);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL clean_press cycle %0d: got %b want %b", i, act_v, exp_v);
      end
      if (ifc.x1) begin cnt++; if (first < 0) first = i; end
      if (ifc.x2 || ifc.x3) other++;
    end
    checks++;
    if (first != 6 || cnt != 1 || other != 0) begin
      errors++;
      $display("FAIL clean_press_latency: got first=%0d count=%0d other=%0d want 6 1 0",
               first, cnt, other);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int g = 0; g < 6; g++) begin
      int          len;
      bit [2:0]    s;
      len = (g == 0) ? 3 : int'($urandom_range(1, DB - 1));
      s   = (g == 0) ? 3'b010 : 3'(1 << $urandom_range(0, 2));
      for (int i = 0; i < len + 10; i++) begin
        cyc((i < len) ? s : 3'b000);
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL glitch %0d cycle %0d: got %b want %b", g, i, act_v, exp_v);
        end
        if (ifc.x1 || ifc.x2 || ifc.x3 || ifc.err) pulses++;
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL glitch_reject: got %0d output pulses want 0", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int errs = 0;
    int xs   = 0;
    for (int i = 0; i < 30; i++) begin
      cyc((i < 10) ? 3'b101 : 3'b000);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL simultaneous cycle %0d: got %b want %b", i, act_v, exp_v);
      end
      if (ifc.err) errs++;
      if (ifc.x1 || ifc.x2 || ifc.x3) xs++;
    end
    checks++;
    if (errs != 1 || xs != 0) begin
      errors++;
      $display("FAIL simultaneous_err: got err=%0d x=%0d want 1 0", errs, xs);
    end
  endtask

  task automatic test_overlap();
    int x2c = 0, x3c = 0, errs = 0, first3 = -1;
    for (int i = 0; i < 80; i++) begin
      bit [2:0] s;
      s = 3'b000;
      if (i < 30) s[1] = 1'b1;
      if (i >= 10 && i < 30) s[2] = 1'b1;
      if (i >= 50 && i < 60) s[2] = 1'b1;
      cyc(s);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL overlap cycle %0d: got %b want %b", i, act_v, exp_v);
      end
      if (ifc.x2) x2c++;
      if (ifc.err) errs++;
      if (ifc.x3) begin x3c++; if (first3 < 0) first3 = i; end
    end
    checks++;
    if (x2c != 1 || errs != 1 || x3c != 1 || first3 != 56) begin
      errors++;
      $display("FAIL overlap_summary: got x2=%0d err=%0d x3=%0d first_x3=%0d want 1 1 1 56",
               x2c, errs, x3c, first3);
    end
  endtask

  task automatic test_reset_mid_lock();
    int first = -1;
    int early = 0;
    for (int i = 0; i < 45; i++) begin
      rd = (i != 8);
      cyc(((i < 8) || (i >= 20 && i < 28)) ? 3'b001 : 3'b000);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_lock cycle %0d: got %b want %b", i, act_v, exp_v);
      end
      if (i == 8) begin
        checks++;
        if (ifc.busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_lock_busy: got %b want 0", ifc.busy);
        end
      end
      if (i > 8 && i < 20 && ifc.x1) early++;
      if (i >= 20 && ifc.x1 && first < 0) first = i;
    end
    rd = 1'b1;
    checks++;
    if (early != 0 || first != 26) begin
      errors++;
      $display("FAIL reset_mid_lock_repress: got early=%0d first=%0d want 0 26", early, first);
    end
  endtask

  task automatic test_random();
    int       hold [3];
    bit [2:0] s;
    s = 3'b000;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          s[c]    = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 14));
        end else begin
          hold[c]--;
        end
      end
      rd = ($urandom_range(0, 299) != 0);
      cyc(s);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random cycle %0d: got %b want %b", i, act_v, exp_v);
      end
    end
    rd = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(3'b000);
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random_drain cycle %0d: got %b want %b", i, act_v, exp_v);
      end
    end
  endtask

  initial begin
    ifc.s3 = 1'b0;
    ifc.s2 = 1'b0;
    ifc.s0 = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_overlap();
    test_reset_mid_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
